clause_eval: RTL and testbench

- Single-clause evaluation block for the binary SAT solver.
- Holds NUM_LITS literal cells. Each cell stores literal presence, polarity, the current value of its variable, and the decision level of that value.
- Continuously classifies the clause as satisfied, conflicting, unit or undetermined, and reports the implied assignment for unit propagation and the conflict level for backtracking.
- Sits between the variable-state store and the BCP/conflict-analysis controller.

---
 rtl/clause_eval.sv | 160 ++++++++++++++++
 tb/tb_clause_eval.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clause_eval.sv
// Single-clause evaluator for the SAT solver: NUM_LITS registered literal cells
// plus combinational classification (sat / conflict / unit) and conflict level.

module clause_eval_cell #(
    parameter int LEVEL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               lit_wr_en,
    input  logic               lit_wr_present,
    input  logic               lit_wr_polarity,
    input  logic               var_wr_en,
    input  logic [1:0]         var_value,
    input  logic [LEVEL_W-1:0] var_level,
    input  logic               backtrack_en,
    input  logic [LEVEL_W-1:0] backtrack_level,
    output logic               present_o,
    output logic               polarity_o,
    output logic [1:0]         lit_value_o,
    output logic [LEVEL_W-1:0] level_o
);
    logic               present_q, present_d;
    logic               pol_q, pol_d;
    logic [1:0]         val_q, val_d;
    logic [LEVEL_W-1:0] lvl_q, lvl_d;

    always_comb begin
        present_d = present_q;
        pol_d     = pol_q;
        val_d     = val_q;
        lvl_d     = lvl_q;
        if (lit_wr_en) begin
            present_d = lit_wr_present;
            pol_d     = lit_wr_polarity;
            val_d     = 2'b00;
            lvl_d     = '0;
        end else if (var_wr_en) begin
            // an illegal value claims the cell but leaves it untouched
            if (var_value != 2'b11) begin
                val_d = var_value;
                lvl_d = var_level;
            end
        end else if (backtrack_en && (val_q != 2'b00) && (lvl_q > backtrack_level)) begin
            val_d = 2'b00;
            lvl_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            present_q <= 1'b0;
            pol_q     <= 1'b0;
            val_q     <= 2'b00;
            lvl_q     <= '0;
        end else begin
            present_q <= present_d;
            pol_q     <= pol_d;
            val_q     <= val_d;
            lvl_q     <= lvl_d;
        end
    end

    always_comb begin
        lit_value_o = 2'b00;
        if (present_q && (val_q != 2'b00))
            lit_value_o = ((val_q == 2'b10) == pol_q) ? 2'b10 : 2'b01;
    end

    assign present_o  = present_q;
    assign polarity_o = pol_q;
    assign level_o    = lvl_q;
endmodule

module clause_eval #(
    parameter int NUM_LITS = 8,
    parameter int IDX_W    = 3,
    parameter int LEVEL_W  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        lit_wr_en,
    input  logic [IDX_W-1:0]            lit_wr_idx,
    input  logic                        lit_wr_present,
    input  logic                        lit_wr_polarity,
    input  logic [NUM_LITS-1:0]         var_wr_en,
    input  logic [2*NUM_LITS-1:0]       var_value_in,
    input  logic [NUM_LITS*LEVEL_W-1:0] var_level_in,
    input  logic                        backtrack_en,
    input  logic [LEVEL_W-1:0]          backtrack_level,
    output logic [2*NUM_LITS-1:0]       lit_value_out,
    output logic                        clause_sat,
    output logic                        clause_conflict,
    output logic                        clause_unit,
    output logic [IDX_W-1:0]            unit_idx,
    output logic [1:0]                  unit_var_value,
    output logic [LEVEL_W-1:0]          max_false_level
);
    logic [NUM_LITS-1:0]              cell_present;
    logic [NUM_LITS-1:0]              cell_pol;
    logic [NUM_LITS-1:0][1:0]         cell_lv;
    logic [NUM_LITS-1:0][LEVEL_W-1:0] cell_lvl;

    for (genvar i = 0; i < NUM_LITS; i++) begin : g_cell
        clause_eval_cell #(.LEVEL_W(LEVEL_W)) u_cell (
            .clk             (clk),
            .rst             (rst),
            .lit_wr_en       (lit_wr_en && (lit_wr_idx == IDX_W'(i))),
            .lit_wr_present  (lit_wr_present),
            .lit_wr_polarity (lit_wr_polarity),
            .var_wr_en       (var_wr_en[i]),
            .var_value       (var_value_in[2*i +: 2]),
            .var_level       (var_level_in[LEVEL_W*i +: LEVEL_W]),
            .backtrack_en    (backtrack_en),
            .backtrack_level (backtrack_level),
            .present_o       (cell_present[i]),
            .polarity_o      (cell_pol[i]),
            .lit_value_o     (cell_lv[i]),
            .level_o         (cell_lvl[i])
        );
    end

    assign lit_value_out = cell_lv;

    logic               any_true, free_seen, free_multi, free_pol;
    logic [IDX_W-1:0]   free_idx;
    logic [LEVEL_W-1:0] mfl;

    always_comb begin
        any_true   = 1'b0;
        free_seen  = 1'b0;
        free_multi = 1'b0;
        free_pol   = 1'b0;
        free_idx   = '0;
        mfl        = '0;
        for (int i = 0; i < NUM_LITS; i++) begin
            if (cell_lv[i] == 2'b10)
                any_true = 1'b1;
            if (cell_present[i] && (cell_lv[i] == 2'b00)) begin
                if (free_seen) begin
                    free_multi = 1'b1;
                end else begin
                    free_seen = 1'b1;
                    free_idx  = IDX_W'(i);
                    free_pol  = cell_pol[i];
                end
            end
            if ((cell_lv[i] == 2'b01) && (cell_lvl[i] > mfl))
                mfl = cell_lvl[i];
        end
    end

    always_comb begin
        clause_sat      = any_true;
        clause_conflict = !any_true && !free_seen;
        clause_unit     = !any_true && free_seen && !free_multi;
        unit_idx        = clause_unit ? free_idx : '0;
        unit_var_value  = clause_unit ? (free_pol ? 2'b10 : 2'b01) : 2'b00;
        max_false_level = mfl;
    end
endmodule

// File: tb/tb_clause_eval.sv
// Bench for clause_eval: directed vector table, randomized run against an
// array-based clause model, and reset/priority corner sequences.

module tb_clause_eval;
    localparam int N  = 8;
    localparam int IW = 3;
    localparam int LW = 16;

    typedef struct {
        logic          lw_en;
        logic [IW-1:0] lw_idx;
        logic          lw_pres;
        logic          lw_pol;
        logic [N-1:0]  vw_en;
        logic [2*N-1:0]  vval;
        logic [N*LW-1:0] vlvl;
        logic          bt_en;
        logic [LW-1:0] bt_lvl;
    } stim_t;

    typedef struct {
        logic          sat;
        logic          conf;
        logic          unit;
        logic [IW-1:0] idx;
        logic [1:0]    uval;
        logic [LW-1:0] mfl;
        logic [2*N-1:0] lv;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic lit_wr_en, lit_wr_present, lit_wr_polarity, backtrack_en;
    logic [IW-1:0] lit_wr_idx;
    logic [N-1:0] var_wr_en;
    logic [2*N-1:0] var_value_in;
    logic [N*LW-1:0] var_level_in;
    logic [LW-1:0] backtrack_level;
    logic [2*N-1:0] lit_value_out;
    logic clause_sat, clause_conflict, clause_unit;
    logic [IW-1:0] unit_idx;
    logic [1:0] unit_var_value;
    logic [LW-1:0] max_false_level;

    int n_chk = 0;
    int n_fail = 0;

    // reference state: one entry per cell
    bit       m_pres [N];
    bit       m_pol  [N];
    int       m_val  [N];
    int       m_lvl  [N];

    clause_eval #(.NUM_LITS(N), .IDX_W(IW), .LEVEL_W(LW)) dut (
        .clk(clk), .rst(rst),
        .lit_wr_en(lit_wr_en), .lit_wr_idx(lit_wr_idx),
        .lit_wr_present(lit_wr_present), .lit_wr_polarity(lit_wr_polarity),
        .var_wr_en(var_wr_en), .var_value_in(var_value_in), .var_level_in(var_level_in),
        .backtrack_en(backtrack_en), .backtrack_level(backtrack_level),
        .lit_value_out(lit_value_out), .clause_sat(clause_sat),
        .clause_conflict(clause_conflict), .clause_unit(clause_unit),
        .unit_idx(unit_idx), .unit_var_value(unit_var_value),
        .max_false_level(max_false_level)
    );

    always #5 clk = ~clk;

    function automatic stim_t mk(input logic lwe, input int idx, input logic pres, input logic pol,
                                 input logic [N-1:0] vwe, input logic [2*N-1:0] vv,
                                 input logic [N*LW-1:0] vl, input logic bte, input int btl);
        stim_t s;
        s.lw_en = lwe; s.lw_idx = IW'(idx); s.lw_pres = pres; s.lw_pol = pol;
        s.vw_en = vwe; s.vval = vv; s.vlvl = vl; s.bt_en = bte; s.bt_lvl = LW'(btl);
        return s;
    endfunction

    function automatic exp_t ex(input logic sat, input logic conf, input logic unit, input int idx,
                                input logic [1:0] uval, input int mfl, input logic [2*N-1:0] lv);
        exp_t e;
        e.sat = sat; e.conf = conf; e.unit = unit; e.idx = IW'(idx);
        e.uval = uval; e.mfl = LW'(mfl); e.lv = lv;
        return e;
    endfunction

    function automatic logic [N*LW-1:0] lv3(input int l2, input int l1, input int l0);
        logic [N*LW-1:0] r;
        r = '0;
        r[0 +: LW] = LW'(l0);
        r[LW +: LW] = LW'(l1);
        r[2*LW +: LW] = LW'(l2);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, " sat"},  64'(clause_sat), 64'(e.sat));
        chk({tag, " conf"}, 64'(clause_conflict), 64'(e.conf));
        chk({tag, " unit"}, 64'(clause_unit), 64'(e.unit));
        chk({tag, " idx"},  64'(unit_idx), 64'(e.idx));
        chk({tag, " uval"}, 64'(unit_var_value), 64'(e.uval));
        chk({tag, " mfl"},  64'(max_false_level), 64'(e.mfl));
        chk({tag, " lv"},   64'(lit_value_out), 64'(e.lv));
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_pres[i] = 0; m_pol[i] = 0; m_val[i] = 0; m_lvl[i] = 0;
        end
    endfunction

    // spec rules: lit write > var write (illegal = no change) > backtrack
    function automatic void model_step(input stim_t s);
        for (int i = 0; i < N; i++) begin
            int v;
            v = int'(s.vval[2*i +: 2]);
            if (s.lw_en && int'(s.lw_idx) == i) begin
                m_pres[i] = s.lw_pres; m_pol[i] = s.lw_pol; m_val[i] = 0; m_lvl[i] = 0;
            end else if (s.vw_en[i]) begin
                if (v != 3) begin
                    m_val[i] = v; m_lvl[i] = int'(s.vlvl[LW*i +: LW]);
                end
            end else if (s.bt_en && m_val[i] != 0 && m_lvl[i] > int'(s.bt_lvl)) begin
                m_val[i] = 0; m_lvl[i] = 0;
            end
        end
    endfunction

    function automatic exp_t model_eval();
        exp_t e;
        int ntrue, nfree, fidx, mfl;
        ntrue = 0; nfree = 0; fidx = 0; mfl = 0;
        e.lv = '0;
        for (int i = 0; i < N; i++) begin
            if (m_pres[i]) begin
                if (m_val[i] == 0) begin
                    nfree++;
                    fidx = i;
                end else if ((m_val[i] == 2) == m_pol[i]) begin
                    ntrue++;
                    e.lv[2*i +: 2] = 2'b10;
                end else begin
                    e.lv[2*i +: 2] = 2'b01;
                    if (m_lvl[i] > mfl) mfl = m_lvl[i];
                end
            end
        end
        e.sat  = ntrue > 0;
        e.conf = ntrue == 0 && nfree == 0;
        e.unit = ntrue == 0 && nfree == 1;
        e.idx  = e.unit ? IW'(fidx) : '0;
        e.uval = e.unit ? (m_pol[fidx] ? 2'b10 : 2'b01) : 2'b00;
        e.mfl  = LW'(mfl);
        return e;
    endfunction

    task automatic idle();
        lit_wr_en = 0; lit_wr_idx = '0; lit_wr_present = 0; lit_wr_polarity = 0;
        var_wr_en = '0; var_value_in = '0; var_level_in = '0;
        backtrack_en = 0; backtrack_level = '0;
    endtask

    task automatic drive(input stim_t s);
        lit_wr_en = s.lw_en; lit_wr_idx = s.lw_idx;
        lit_wr_present = s.lw_pres; lit_wr_polarity = s.lw_pol;
        var_wr_en = s.vw_en; var_value_in = s.vval; var_level_in = s.vlvl;
        backtrack_en = s.bt_en; backtrack_level = s.bt_lvl;
        @(posedge clk);
        model_step(s);
        #1;
        idle();
    endtask

    vec_t tbl[14];
    exp_t e_rst;

    initial begin
        idle();
        rst = 1;
        @(posedge clk); @(posedge clk);
        #1;
        rst = 0;
        model_reset();
        e_rst = ex(0, 1, 0, 0, 2'b00, 0, 16'h0000);
        chk_all("reset", e_rst);

        tbl[0]  = '{mk(1, 0, 1, 1, 8'h00, 16'h0000, '0, 0, 0),          ex(0, 0, 1, 0, 2'b10, 0, 16'h0000)};
        tbl[1]  = '{mk(1, 1, 1, 0, 8'h00, 16'h0000, '0, 0, 0),          ex(0, 0, 0, 0, 2'b00, 0, 16'h0000)};
        tbl[2]  = '{mk(1, 2, 1, 1, 8'h00, 16'h0000, '0, 0, 0),          ex(0, 0, 0, 0, 2'b00, 0, 16'h0000)};
        tbl[3]  = '{mk(0, 0, 0, 0, 8'h03, 16'h0009, lv3(0, 2, 1), 0, 0), ex(0, 0, 1, 2, 2'b10, 2, 16'h0005)};
        tbl[4]  = '{mk(0, 0, 0, 0, 8'h04, 16'h0010, lv3(3, 0, 0), 0, 0), ex(0, 1, 0, 0, 2'b00, 3, 16'h0015)};
        tbl[5]  = '{mk(0, 0, 0, 0, 8'h00, 16'h0000, '0, 1, 2),          ex(0, 0, 1, 2, 2'b10, 2, 16'h0005)};
        tbl[6]  = '{mk(0, 0, 0, 0, 8'h04, 16'h0020, lv3(3, 0, 0), 0, 0), ex(1, 0, 0, 0, 2'b00, 2, 16'h0025)};
        tbl[7]  = '{mk(0, 0, 0, 0, 8'h00, 16'h0000, '0, 1, 0),          ex(0, 0, 0, 0, 2'b00, 0, 16'h0000)};
        tbl[8]  = '{mk(0, 0, 0, 0, 8'h01, 16'h0002, lv3(0, 0, 1), 0, 0), ex(1, 0, 0, 0, 2'b00, 0, 16'h0002)};
        tbl[9]  = '{mk(0, 0, 0, 0, 8'h02, 16'h0004, lv3(0, 2, 0), 0, 0), ex(1, 0, 0, 0, 2'b00, 0, 16'h000A)};
        tbl[10] = '{mk(1, 1, 1, 1, 8'h03, 16'h000B, lv3(0, 5, 7), 1, 1), ex(1, 0, 0, 0, 2'b00, 0, 16'h0002)};
        tbl[11] = '{mk(0, 0, 0, 0, 8'h02, 16'h0008, lv3(0, 4, 0), 0, 0), ex(1, 0, 0, 0, 2'b00, 0, 16'h000A)};
        tbl[12] = '{mk(0, 0, 0, 0, 8'h03, 16'h0005, lv3(0, 4, 2), 0, 0), ex(0, 0, 1, 2, 2'b10, 4, 16'h0005)};
        tbl[13] = '{mk(1, 2, 1, 0, 8'h00, 16'h0000, '0, 0, 0),          ex(0, 0, 1, 2, 2'b01, 4, 16'h0005)};

        for (int k = 0; k < 14; k++) begin
            drive(tbl[k].s);
            chk_all($sformatf("vec%0d", k), tbl[k].e);
        end

        for (int k = 0; k < 400; k++) begin
            stim_t s;
            s.lw_en   = ($urandom_range(0, 3) == 0);
            s.lw_idx  = IW'($urandom_range(0, N - 1));
            s.lw_pres = ($urandom_range(0, 4) != 0);
            s.lw_pol  = 1'($urandom);
            s.vw_en   = '0;
            s.vval    = '0;
            s.vlvl    = '0;
            for (int i = 0; i < N; i++) begin
                s.vw_en[i] = ($urandom_range(0, 2) == 0);
                s.vval[2*i +: 2] = 2'($urandom);
                s.vlvl[LW*i +: LW] = LW'($urandom_range(0, 7));
            end
            s.bt_en  = ($urandom_range(0, 5) == 0);
            s.bt_lvl = LW'($urandom_range(0, 7));
            drive(s);
            chk_all($sformatf("rnd%0d", k), model_eval());
        end

        // reset wins over simultaneous writes on a populated clause
        drive(mk(0, 0, 0, 0, 8'h07, 16'h0026, lv3(3, 2, 1), 0, 0));
        lit_wr_en = 1; lit_wr_idx = 3'd4; lit_wr_present = 1; lit_wr_polarity = 1;
        var_wr_en = 8'hFF; var_value_in = 16'hAAAA; var_level_in = {8{16'd9}};
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        idle();
        model_reset();
        chk_all("midreset", e_rst);

        drive(mk(1, 5, 1, 0, 8'h00, 16'h0000, '0, 0, 0));
        chk_all("post_reset_prog", ex(0, 0, 1, 5, 2'b01, 0, 16'h0000));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
